// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory port arbiter.
//   arb_state_t : sequencer states (IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE)
//   GNT_*       : owner encoding driven on gnt_id and used as rr_last values
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_LD   = 2'd1;
   localparam logic [1:0] GNT_LS   = 2'd2;
   localparam logic [1:0] GNT_IF   = 2'd3;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection for the memory port arbiter.
//   ld_req, ls_req, if_req : request levels
//   rr_last                : last LS/IF owner granted (GNT_LS or GNT_IF)
//   winner                 : GNT_* code of the selected requester
//   valid                  : at least one request present
// LD always wins. When LS and IF both request, the one that was not
// served last gets the port.
// -----------------------------------------------------------------------------
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       ld_req,
   input  logic       ls_req,
   input  logic       if_req,
   input  logic [1:0] rr_last,
   output logic [1:0] winner,
   output logic       valid
);

   always_comb begin
      winner = GNT_NONE;
      valid  = 1'b0;
      if (ld_req) begin
         winner = GNT_LD;
         valid  = 1'b1;
      end else if (ls_req && if_req) begin
         winner = (rr_last == GNT_LS) ? GNT_IF : GNT_LS;
         valid  = 1'b1;
      end else if (ls_req) begin
         winner = GNT_LS;
         valid  = 1'b1;
      end else if (if_req) begin
         winner = GNT_IF;
         valid  = 1'b1;
      end
   end

endmodule : mem_arb_pick

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous memory port between the program loader (LD), the
// CPU load/store path (LS) and the CPU instruction fetch (IF). One
// transaction is in flight at a time.
//
// Ports
//   clk, rst                 : clock, asynchronous active-low reset
//   ld_req/we/addr/wdata     : loader request and operands
//   ls_req/we/addr/wdata     : load/store request and operands
//   if_req/addr              : fetch request (read only)
//   ld_done/ls_done/if_done  : one-cycle completion pulses
//   rdata                    : last read result, held until the next read
//   mem_en/we/addr/wdata     : memory command, one mem_en cycle per access
//   mem_rdata                : memory read data, valid MEM_LAT cycles after mem_en
//   busy                     : high whenever the sequencer is not IDLE
//   gnt_id                   : current owner (GNT_NONE/LD/LS/IF)
//
// Request protocol: a requester raises req (level) with stable operands and
// holds both until it sees its done pulse, then drops req by the clock edge
// that ends the done cycle. Requests are only sampled in IDLE, so a req that
// is still high during RESP cannot be served twice. Operands are captured
// on the granting edge and later changes are ignored.
//
// MEM_LAT legal range is 1..15 (4-bit wait counter).
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              ld_done,
   output logic              ls_done,
   output logic              if_done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [1:0]        gnt_id
);

   // WAIT lasts MEM_LAT cycles: the counter is loaded with MEM_LAT-1 in
   // ISSUE and WAIT ends on the cycle it reads zero.
   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [1:0]        rr_last;
   logic [3:0]        wait_cnt;
   logic              op_we;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_wdata;

   logic [1:0]        pick_winner;
   logic              pick_valid;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   mem_arb_pick u_pick (
      .ld_req  (ld_req),
      .ls_req  (ls_req),
      .if_req  (if_req),
      .rr_last (rr_last),
      .winner  (pick_winner),
      .valid   (pick_valid)
   );

   // Operands of the requester the picker selects this cycle.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      case (pick_winner)
         GNT_LD: begin
            sel_we    = ld_we;
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
         end
         GNT_LS: begin
            sel_we    = ls_we;
            sel_addr  = ls_addr;
            sel_wdata = ls_wdata;
         end
         GNT_IF: begin
            sel_addr  = if_addr;
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = ISSUE;
         ISSUE:   state_nxt = op_we ? RESP : WAIT;
         WAIT:    if (wait_cnt == 4'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Owner, operand latch, wait counter, read capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_id   <= GNT_NONE;
         rr_last  <= GNT_IF;
         wait_cnt <= 4'd0;
         op_we    <= 1'b0;
         op_addr  <= '0;
         op_wdata <= '0;
         rdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt_id   <= pick_winner;
                  op_we    <= sel_we;
                  op_addr  <= sel_addr;
                  op_wdata <= sel_wdata;
                  // LD grants must not disturb the LS/IF rotation.
                  if (pick_winner != GNT_LD) rr_last <= pick_winner;
               end
            end
            ISSUE: wait_cnt <= LAT_M1;
            WAIT: begin
               if (wait_cnt == 4'd0) rdata    <= mem_rdata;
               else                  wait_cnt <= wait_cnt - 4'd1;
            end
            RESP: gnt_id <= GNT_NONE;
            default: ;
         endcase
      end
   end

   // Memory command is only non-zero during ISSUE.
   assign mem_en    = (state == ISSUE);
   assign mem_we    = mem_en & op_we;
   assign mem_addr  = mem_en ? op_addr  : '0;
   assign mem_wdata = mem_en ? op_wdata : '0;

   assign ld_done = (state == RESP) && (gnt_id == GNT_LD);
   assign ls_done = (state == RESP) && (gnt_id == GNT_LS);
   assign if_done = (state == RESP) && (gnt_id == GNT_IF);
   assign busy    = (state != IDLE);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. The main instance uses MEM_LAT=2;
// two extra instances built with MEM_LAT=1 and MEM_LAT=15 cover the
// latency extremes. Each instance gets a small memory model that drives
// mem_rdata with the stored word only on the exact cycle it is due and
// with a junk pattern otherwise. Unwritten words read back as
// addr ^ 32'h5A5A5A5A.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main instance
   logic        ld_req, ld_we, ls_req, ls_we, if_req;
   logic [31:0] ld_addr, ld_wdata, ls_addr, ls_wdata, if_addr;
   logic        ld_done, ls_done, if_done, mem_en, mem_we, busy;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  gnt_id;

   // latency-1 and latency-15 instances (IF requests only)
   logic        a_if_req, b_if_req;
   logic [31:0] a_if_addr, b_if_addr;
   logic        a_ld_done, a_ls_done, a_if_done, a_mem_en, a_mem_we, a_busy;
   logic        b_ld_done, b_ls_done, b_if_done, b_mem_en, b_mem_we, b_busy;
   logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [1:0]  a_gnt_id, b_gnt_id;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .clk(clk), .rst(rst),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .if_req(if_req), .if_addr(if_addr),
      .ld_done(ld_done), .ls_done(ls_done), .if_done(if_done), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
      .clk(clk), .rst(rst),
      .ld_req(1'b0), .ld_we(1'b0), .ld_addr(32'd0), .ld_wdata(32'd0),
      .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'd0), .ls_wdata(32'd0),
      .if_req(a_if_req), .if_addr(a_if_addr),
      .ld_done(a_ld_done), .ls_done(a_ls_done), .if_done(a_if_done), .rdata(a_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .busy(a_busy), .gnt_id(a_gnt_id)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut_l15 (
      .clk(clk), .rst(rst),
      .ld_req(1'b0), .ld_we(1'b0), .ld_addr(32'd0), .ld_wdata(32'd0),
      .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'd0), .ls_wdata(32'd0),
      .if_req(b_if_req), .if_addr(b_if_addr),
      .ld_done(b_ld_done), .ls_done(b_ls_done), .if_done(b_if_done), .rdata(b_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .busy(b_busy), .gnt_id(b_gnt_id)
   );

   // ---------------------------------------------------------------- memory
   logic [31:0] mem_arr [logic [31:0]];

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a ^ 32'h5A5A_5A5A;
   endfunction

   // cycles since the last mem_en, saturating at 31
   logic [4:0]  m_cnt = 5'd31, a_cnt = 5'd31, b_cnt = 5'd31;
   logic [31:0] m_a = 32'd0, a_a = 32'd0, b_a = 32'd0;
   logic        m_rd = 1'b0, a_rd = 1'b0, b_rd = 1'b0;

   always @(posedge clk) begin
      if (mem_en) begin
         m_cnt <= 5'd1; m_a <= mem_addr; m_rd <= !mem_we;
      end else if (m_cnt != 5'd31) m_cnt <= m_cnt + 5'd1;
      if (a_mem_en) begin
         a_cnt <= 5'd1; a_a <= a_mem_addr; a_rd <= !a_mem_we;
      end else if (a_cnt != 5'd31) a_cnt <= a_cnt + 5'd1;
      if (b_mem_en) begin
         b_cnt <= 5'd1; b_a <= b_mem_addr; b_rd <= !b_mem_we;
      end else if (b_cnt != 5'd31) b_cnt <= b_cnt + 5'd1;
   end

   always @(negedge clk) begin
      if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
   end

   assign mem_rdata   = (m_rd && m_cnt == 5'd2)  ? mem_val(m_a) : (32'hBAD0_0000 | {27'd0, m_cnt});
   assign a_mem_rdata = (a_rd && a_cnt == 5'd1)  ? mem_val(a_a) : (32'hBAD1_0000 | {27'd0, a_cnt});
   assign b_mem_rdata = (b_rd && b_cnt == 5'd15) ? mem_val(b_a) : (32'hBAD2_0000 | {27'd0, b_cnt});

   // ------------------------------------------------------------ scoreboard
   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_cyc_q[$];
   logic [31:0] exp_rd_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------- driver tasks
   task automatic idle_inputs();
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = 32'd0; ld_wdata = 32'd0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
      if_req = 1'b0; if_addr = 32'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Waits for the done pulse of requester 'who' (1 LD, 2 LS, 3 IF),
   // counting cycles from 'start'; n is the cycle the pulse was seen.
   task automatic wait_done(input int who, input int start, input int budget, output int n);
      logic hit;
      hit = 1'b0;
      n   = start;
      while (!hit && n < start + budget) begin
         @(negedge clk);
         n++;
         case (who)
            1: hit = ld_done;
            2: hit = ls_done;
            3: hit = if_done;
            default: hit = 1'b0;
         endcase
      end
      check("done_seen", {31'd0, hit}, 32'd1);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int n;
      int cyc;
      int dones;
      int a_n;
      int b_n;
      logic ls_rearm;
      logic if_rearm;
      logic [31:0] who;

      idle_inputs();
      a_if_req = 1'b0; a_if_addr = 32'd0;
      b_if_req = 1'b0; b_if_addr = 32'd0;
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // reset values
      check("rst_busy",   {31'd0, busy}, 32'd0);
      check("rst_gnt",    {30'd0, gnt_id}, 32'd0);
      check("rst_mem_en", {31'd0, mem_en}, 32'd0);
      check("rst_addr",   mem_addr, 32'd0);
      check("rst_rdata",  rdata, 32'd0);
      check("rst_done",   {29'd0, ld_done, ls_done, if_done}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // single IF read
      mem_arr[32'h40] = 32'hDEAD_BEEF;
      if_req = 1'b1; if_addr = 32'h40;
      @(negedge clk);
      check("if_mem_en",   {31'd0, mem_en}, 32'd1);
      check("if_mem_addr", mem_addr, 32'h40);
      check("if_mem_we",   {31'd0, mem_we}, 32'd0);
      check("if_gnt",      {30'd0, gnt_id}, 32'd3);
      wait_done(3, 1, 20, n);
      check("if_done_cyc", n, 32'd4);
      check("if_rdata",    rdata, 32'hDEAD_BEEF);
      if_req = 1'b0;
      @(negedge clk);
      check("if_idle", {31'd0, busy}, 32'd0);

      // LS write
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'h1234_5678;
      @(negedge clk);
      check("wr_mem_en",    {31'd0, mem_en}, 32'd1);
      check("wr_mem_we",    {31'd0, mem_we}, 32'd1);
      check("wr_mem_addr",  mem_addr, 32'h100);
      check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
      check("wr_gnt",       {30'd0, gnt_id}, 32'd2);
      wait_done(2, 1, 20, n);
      check("wr_done_cyc",  n, 32'd2);
      check("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
      ls_req = 1'b0; ls_we = 1'b0;
      @(negedge clk);
      check("wr_we_clear",    {31'd0, mem_we}, 32'd0);
      check("wr_addr_clear",  mem_addr, 32'd0);
      check("wr_wdata_clear", mem_wdata, 32'd0);

      // LS/IF round robin from reset: LS first, then strict alternation
      do_reset();
      ls_addr = 32'h300; if_addr = 32'h200;
      ls_req = 1'b1; if_req = 1'b1;
      ls_rearm = 1'b0; if_rearm = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'd2); exp_rd_q.push_back(32'h5A5A_595A);
         exp_q.push_back(32'd3); exp_rd_q.push_back(32'h5A5A_585A);
      end
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (ls_rearm) begin ls_req = 1'b1; ls_rearm = 1'b0; end
         if (if_rearm) begin if_req = 1'b1; if_rearm = 1'b0; end
         if (ls_done || if_done) begin
            who = ls_done ? 32'd2 : 32'd3;
            check("rr_order", who, exp_q.pop_front());
            check("rr_rdata", rdata, exp_rd_q.pop_front());
            if (ls_done) begin ls_req = 1'b0; ls_rearm = 1'b1; end
            else         begin if_req = 1'b0; if_rearm = 1'b1; end
            if (exp_q.size() == 0) begin
               ls_req = 1'b0; if_req = 1'b0; ls_rearm = 1'b0; if_rearm = 1'b0;
            end
         end
      end
      check("rr_all_served", exp_q.size(), 32'd0);

      // LD + LS + IF together: LD first, then LS (rr_last still IF), then IF
      @(negedge clk);
      exp_q.delete(); exp_cyc_q.delete(); exp_rd_q.delete();
      exp_q.push_back(32'd1); exp_cyc_q.push_back(32'd2);  exp_rd_q.push_back(32'h5A5A_585A);
      exp_q.push_back(32'd2); exp_cyc_q.push_back(32'd7);  exp_rd_q.push_back(32'hCAFE_F00D);
      exp_q.push_back(32'd3); exp_cyc_q.push_back(32'd12); exp_rd_q.push_back(32'hDEAD_BEEF);
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h500; ld_wdata = 32'hCAFE_F00D;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500;
      if_req = 1'b1; if_addr = 32'h40;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            check("pri_gnt",    {30'd0, gnt_id}, 32'd1);
            check("pri_mem_we", {31'd0, mem_we}, 32'd1);
         end
         if (ld_done || ls_done || if_done) begin
            who = ld_done ? 32'd1 : (ls_done ? 32'd2 : 32'd3);
            check("pri_order", who, exp_q.pop_front());
            check("pri_cycle", cyc, exp_cyc_q.pop_front());
            check("pri_rdata", rdata, exp_rd_q.pop_front());
            if (ld_done) ld_req = 1'b0;
            if (ls_done) ls_req = 1'b0;
            if (if_done) if_req = 1'b0;
         end
      end
      check("pri_all_served", exp_q.size(), 32'd0);
      idle_inputs();

      // reset during WAIT aborts with no done pulse
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h40;
      repeat (2) @(negedge clk);
      check("abort_busy_pre", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      if_req = 1'b0;
      #1;
      check("abort_busy",   {31'd0, busy}, 32'd0);
      check("abort_gnt",    {30'd0, gnt_id}, 32'd0);
      check("abort_mem_en", {31'd0, mem_en}, 32'd0);
      check("abort_rdata",  rdata, 32'd0);
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (if_done) dones++;
         if (i == 2) rst = 1'b1;
      end
      check("abort_no_done", dones, 32'd0);
      if_req = 1'b1; if_addr = 32'h80;
      wait_done(3, 0, 20, n);
      check("post_rst_cyc",   n, 32'd4);
      check("post_rst_rdata", rdata, 32'h5A5A_5ADA);
      if_req = 1'b0;

      // latency extremes
      @(negedge clk);
      a_if_req = 1'b1; a_if_addr = 32'h40;
      b_if_req = 1'b1; b_if_addr = 32'h44;
      a_n = 0; b_n = 0; cyc = 0;
      while ((a_n == 0 || b_n == 0) && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (a_if_done) begin
            a_n = cyc;
            check("lat1_rdata", a_rdata, 32'hDEAD_BEEF);
            a_if_req = 1'b0;
         end
         if (b_if_done) begin
            b_n = cyc;
            check("lat15_rdata", b_rdata, 32'h5A5A_5A1E);
            b_if_req = 1'b0;
         end
      end
      check("lat1_cyc",  a_n, 32'd3);
      check("lat15_cyc", b_n, 32'd17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule : tb_mem_port_arbiter
